pe_simd_mac: RTL and testbench



---
 rtl/pe_simd_mac.sv | 185 ++++++++++++++++++
 tb/tb_pe_simd_mac.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pe_simd_mac.sv
// Systolic SIMD multiply-accumulate PE: lane-wise products accumulated over DEPTH beats.
// Operands are forwarded downstream. Define PE_SAT_EN for saturating accumulation with overflow flags.
module pe_simd_mac #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     signed_mode,
    input  logic                     in_valid,
    input  logic [LANES*LANE_W-1:0]  in_a,
    input  logic [LANES*LANE_W-1:0]  in_b,
    output logic                     out_valid,
    output logic [LANES*LANE_W-1:0]  out_a,
    output logic [LANES*LANE_W-1:0]  out_b,
    output logic [LANES*ACC_W-1:0]   acc,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [LANES-1:0]         ovf
);

    localparam int unsigned DW    = LANES * LANE_W;
    localparam int unsigned AW    = LANES * ACC_W;
    localparam int unsigned PW    = 2 * LANE_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [LANES-1:0] ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_a_q, out_a_d;
    logic [DW-1:0]    out_b_q, out_b_d;
    logic             result_valid_q, result_valid_d;

    logic [AW-1:0]    ext_all;
    logic [AW-1:0]    sum_all;
    logic [LANES-1:0] clamp;

    // Per-lane product, extension and accumulate (no carry across lanes)
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0]       a_l, b_l;
        logic [PW-1:0]           a_sx, b_sx, prod_s, prod_u;
        logic signed [ACC_W-1:0] ext_s;
        logic [ACC_W-1:0]        ext_u, ext, acc_l, sum;

        assign a_l    = in_a[g*LANE_W +: LANE_W];
        assign b_l    = in_b[g*LANE_W +: LANE_W];
        assign a_sx   = {{LANE_W{a_l[LANE_W-1]}}, a_l};
        assign b_sx   = {{LANE_W{b_l[LANE_W-1]}}, b_l};
        // Low PW bits of the sign-extended product equal the signed product
        assign prod_s = a_sx * b_sx;
        assign prod_u = {{LANE_W{1'b0}}, a_l} * {{LANE_W{1'b0}}, b_l};
        assign ext_s  = ACC_W'($signed(prod_s));
        assign ext_u  = ACC_W'(prod_u);
        assign ext    = signed_mode ? ext_s : ext_u;
        assign acc_l  = acc_q[g*ACC_W +: ACC_W];

`ifdef PE_SAT_EN
        logic [ACC_W:0]   sum_u;
        logic [ACC_W-1:0] sum_w;
        logic             s_ovf;
        logic             u_ovf;

        assign sum_u = {1'b0, acc_l} + {1'b0, ext};
        assign sum_w = sum_u[ACC_W-1:0];
        assign s_ovf = (acc_l[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_l[ACC_W-1]);
        assign u_ovf = sum_u[ACC_W];

        always_comb begin
            sum      = sum_w;
            clamp[g] = 1'b0;
            if (signed_mode) begin
                if (s_ovf) begin
                    clamp[g] = 1'b1;
                    sum      = acc_l[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end else if (u_ovf) begin
                clamp[g] = 1'b1;
                sum      = {ACC_W{1'b1}};
            end
        end
`else
        assign sum      = acc_l + ext;
        assign clamp[g] = 1'b0;
`endif

        assign ext_all[g*ACC_W +: ACC_W] = ext;
        assign sum_all[g*ACC_W +: ACC_W] = sum;
    end

    // Next-state: forwarding path plus ACCUM/DONE control
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        out_valid_d    = in_valid;
        out_a_d        = in_valid ? in_a : out_a_q;
        out_b_d        = in_valid ? in_b : out_b_q;
        result_valid_d = 1'b0;

        if (!en) begin
            state_d     = ST_ACCUM;
            cnt_d       = '0;
            acc_d       = '0;
            ovf_d       = '0;
            out_valid_d = 1'b0;
            out_a_d     = '0;
            out_b_d     = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum_all;
                        ovf_d = ovf_q | clamp;
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        ovf_d = '0;
                        if (in_valid) begin
                            // Overlapping beat starts the next tile; with DEPTH=1 it also ends it
                            acc_d   = ext_all;
                            cnt_d   = CNT_ONE;
                            state_d = (DEPTH == 1) ? ST_DONE : ST_ACCUM;
                        end else begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_ACCUM;
                        end
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
            result_valid_d = (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_ACCUM;
            cnt_q          <= '0;
            acc_q          <= '0;
            ovf_q          <= '0;
            out_valid_q    <= 1'b0;
            out_a_q        <= '0;
            out_b_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_a_q        <= out_a_d;
            out_b_q        <= out_b_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign acc          = acc_q;
    assign result_valid = result_valid_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_pe_simd_mac.sv
// Directed self-checking bench for pe_simd_mac (LANES=2, LANE_W=16, ACC_W=32, DEPTH=4).
module tb_pe_simd_mac;

    logic        clk;
    logic        rst;
    logic        en;
    logic        signed_mode;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [63:0] acc;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  ovf;

    int n_checks;
    int n_fail;

    localparam logic [31:0] VA = 32'h0002_0003;
    localparam logic [31:0] VB = 32'hFFFF_0005;
    localparam logic [63:0] RES1 = 64'hFFFFFFF8_0000003C;

    pe_simd_mac #(
        .LANES (2),
        .LANE_W(16),
        .ACC_W (32),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_a       (out_a),
        .out_b       (out_b),
        .acc         (acc),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; return just after the next rising edge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rr);
        @(negedge clk);
        in_valid     = v;
        in_a         = a;
        in_b         = b;
        result_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) step(1'b1, a, b, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        en           = 1'b1;
        signed_mode  = 1'b1;
        in_valid     = 1'b0;
        in_a         = 32'h1234_5678;
        in_b         = 32'h9ABC_DEF0;
        result_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_acc", acc, 64'h0);
        check("reset_rv", {63'h0, result_valid}, 64'h0);
        check("reset_ov", {63'h0, out_valid}, 64'h0);
        check("reset_outa", {32'h0, out_a}, 64'h0);
        check("reset_ovf", {62'h0, ovf}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic run with forwarding checks
        step(1'b1, VA, VB, 1'b0);
        check("s1_ov", {63'h0, out_valid}, 64'h1);
        check("s1_outa", {32'h0, out_a}, {32'h0, VA});
        check("s1_outb", {32'h0, out_b}, {32'h0, VB});
        step(1'b1, VA, VB, 1'b0);
        step(1'b1, VA, VB, 1'b0);
        check("s1_rv_early", {63'h0, result_valid}, 64'h0);
        step(1'b1, VA, VB, 1'b0);
        check("s1_rv", {63'h0, result_valid}, 64'h1);
        check("s1_acc", acc, RES1);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("s1_bubble_ov", {63'h0, out_valid}, 64'h0);
        check("s1_hold_outa", {32'h0, out_a}, {32'h0, VA});
        // Beat in DONE without ready: forwarded, not accumulated
        step(1'b1, 32'h0005_0005, 32'h0005_0005, 1'b0);
        check("done_frozen", acc, RES1);
        check("done_fwd", {32'h0, out_a}, 64'h0000_0000_0005_0005);
        check("done_rv", {63'h0, result_valid}, 64'h1);

        // Pop with simultaneous beat
        step(1'b1, 32'h0001_0001, 32'h0001_0007, 1'b1);
        check("s3_rv", {63'h0, result_valid}, 64'h0);
        check("s3_acc", acc, 64'h00000001_00000007);
        // Counter restarted at 1: three more beats finish the run
        step(1'b1, VA, VB, 1'b0);
        step(1'b1, VA, VB, 1'b0);
        check("s3_rv_early", {63'h0, result_valid}, 64'h0);
        step(1'b1, VA, VB, 1'b0);
        check("s3_rv_done", {63'h0, result_valid}, 64'h1);
        check("s3_acc_done", acc, 64'hFFFFFFFB_00000034);
        pop();
        check("pop_rv", {63'h0, result_valid}, 64'h0);
        check("pop_acc", acc, 64'h0);

        // Bubbles interleaved; result_ready ignored in ACCUM
        step(1'b1, VA, VB, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, VA, VB, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("s2_mid_acc", acc, 64'hFFFFFFFC_0000001E);
        step(1'b1, VA, VB, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("s2_rv_early", {63'h0, result_valid}, 64'h0);
        step(1'b1, VA, VB, 1'b0);
        check("s2_rv", {63'h0, result_valid}, 64'h1);
        check("s2_acc", acc, RES1);
        pop();

        // Mid-run synchronous clear
        step(1'b1, VA, VB, 1'b0);
        step(1'b1, VA, VB, 1'b0);
        en = 1'b0;
        step(1'b1, VA, VB, 1'b0);
        check("s4_acc", acc, 64'h0);
        check("s4_ov", {63'h0, out_valid}, 64'h0);
        check("s4_outa", {32'h0, out_a}, 64'h0);
        en = 1'b1;
        run4(VA, VB);
        check("s4_rv", {63'h0, result_valid}, 64'h1);
        check("s4_acc_done", acc, RES1);
        pop();

        // Overflow on lane 0
        run4(32'h0000_7FFF, 32'h0000_7FFF);
`ifdef PE_SAT_EN
        check("s5_acc", acc, 64'h00000000_7FFFFFFF);
        check("s5_ovf", {62'h0, ovf}, 64'h1);
`else
        check("s5_acc", acc, 64'h00000000_FFFC0004);
        check("s5_ovf", {62'h0, ovf}, 64'h0);
`endif
        pop();
        check("s5_ovf_pop", {62'h0, ovf}, 64'h0);

        // Unsigned vs signed interpretation
        signed_mode = 1'b0;
        run4(32'h0000_FFFF, 32'h0000_0002);
        check("s6_uns", acc, 64'h00000000_0007FFF8);
        pop();
        signed_mode = 1'b1;
        run4(32'h0000_FFFF, 32'h0000_0002);
        check("s6_sgn", acc, 64'h00000000_FFFFFFF8);

        // Clear while result is pending
        en = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("clr_done_rv", {63'h0, result_valid}, 64'h0);
        check("clr_done_acc", acc, 64'h0);
        en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
